// File: rtl/sigma_delta_ctrl_pkg.sv
// Shared types and constants for the sigma-delta background controller.
package sd_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  localparam pixel_t SD_VAR_MIN = 8'd2;

  function automatic pixel_t abs_diff(input pixel_t a, input pixel_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sigma_delta_ctrl_if.sv
// Pixel stream, model RAM, update core and status bundle of the sigma-delta controller.
interface sigma_delta_ctrl_if
  import sd_pkg::*;
#(
  parameter int ADDR_W = 19
);
  logic              pix_valid;
  logic              pix_ready;
  pixel_t            pix_data;
  logic              pix_sof;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  pixel_t            mem_rd_bg;
  pixel_t            mem_rd_var;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  pixel_t            mem_wr_bg;
  pixel_t            mem_wr_var;

  logic              upd_enable;
  logic              upd_wr_background;
  pixel_t            upd_curr_pixel;
  pixel_t            upd_background;
  pixel_t            upd_variance;
  pixel_t            upd_background_next;
  pixel_t            upd_variance_next;

  logic              mask_valid;
  logic              mask_bit;
  logic              frame_done;
  logic              frame_err;

  modport master (
    input  pix_valid, pix_data, pix_sof,
    output pix_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_bg, mem_rd_var,
    output mem_wr_en, mem_wr_addr, mem_wr_bg, mem_wr_var,
    output upd_enable, upd_wr_background, upd_curr_pixel, upd_background, upd_variance,
    input  upd_background_next, upd_variance_next,
    output mask_valid, mask_bit, frame_done, frame_err
  );

  modport slave (
    output pix_valid, pix_data, pix_sof,
    input  pix_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_bg, mem_rd_var,
    input  mem_wr_en, mem_wr_addr, mem_wr_bg, mem_wr_var,
    input  upd_enable, upd_wr_background, upd_curr_pixel, upd_background, upd_variance,
    output upd_background_next, upd_variance_next,
    input  mask_valid, mask_bit, frame_done, frame_err
  );

endinterface

// File: rtl/sigma_delta_ctrl_frame_counter.sv
// Pixel address counter: addr is the running count, last/wrap describe the pixel being stepped.
// restart makes the stepped pixel address 0 (sof resync); wraps to 0 after the final pixel.
module sd_frame_counter #(
  parameter int ADDR_W    = 19,
  parameter int FRAME_LEN = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              wrap
);

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] eff;

  assign eff  = restart ? '0 : cnt;
  assign last = (eff == ADDR_W'(FRAME_LEN - 1));
  assign wrap = step && last;
  assign addr = cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= last ? '0 : eff + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sigma_delta_ctrl.sv
// Sigma-delta background controller: reads the model at accept, writes back 1 cycle later.
// Latency accept->write 1 cycle; never backpressures (pix_ready tied 1). Optional mask: SD_MASK_EN.
module sigma_delta_ctrl
  import sd_pkg::*;
#(
  parameter int     IMG_W    = 640,
  parameter int     IMG_H    = 480,
  parameter int     ADDR_W   = 19,
  parameter pixel_t VAR_INIT = SD_VAR_MIN
) (
  input  logic              clk,
  input  logic              rst,
  sigma_delta_ctrl_if.master bus
);

  ctrl_state_t       state, state_nxt;
  logic              accept, start, resync, err;
  logic [ADDR_W-1:0] cnt_addr, rd_addr;
  logic              last, wrap;

  logic              s1_vld, s1_last, s1_err, first_frame, act;
  pixel_t            s1_pix;
  logic [ADDR_W-1:0] s1_addr;

  assign bus.pix_ready = 1'b1;
  assign accept = bus.pix_valid && rst;
  assign start  = accept && ((state == RUN) || bus.pix_sof);
  assign resync = start && bus.pix_sof;
  assign err    = resync && (state == RUN) && (cnt_addr != '0);
  assign rd_addr = resync ? '0 : cnt_addr;

  sd_frame_counter #(
    .ADDR_W   (ADDR_W),
    .FRAME_LEN(IMG_W * IMG_H)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .step   (start),
    .restart(resync),
    .addr   (cnt_addr),
    .last   (last),
    .wrap   (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = wrap ? IDLE : RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld      <= 1'b0;
      s1_pix      <= '0;
      s1_addr     <= '0;
      s1_last     <= 1'b0;
      s1_err      <= 1'b0;
      first_frame <= 1'b1;
    end else begin
      s1_vld <= start;
      if (start) begin
        s1_pix  <= bus.pix_data;
        s1_addr <= rd_addr;
        s1_last <= last;
        s1_err  <= err;
      end
      if (act && s1_last) first_frame <= 1'b0;
    end
  end

  // Gating with rst drops the in-flight write when reset lands right after an accept.
  assign act = s1_vld && rst;

  assign bus.mem_rd_en         = start;
  assign bus.mem_rd_addr       = start ? rd_addr : '0;

  assign bus.upd_enable        = act;
  assign bus.upd_wr_background = act && first_frame;
  assign bus.upd_curr_pixel    = act ? s1_pix : '0;
  assign bus.upd_background    = act ? bus.mem_rd_bg : '0;
  assign bus.upd_variance      = act ? bus.mem_rd_var : '0;

  assign bus.mem_wr_en         = act;
  assign bus.mem_wr_addr       = act ? s1_addr : '0;
  assign bus.mem_wr_bg         = act ? bus.upd_background_next : '0;
  assign bus.mem_wr_var        = !act ? '0 : (first_frame ? VAR_INIT : bus.upd_variance_next);

  assign bus.frame_done        = act && s1_last;
  assign bus.frame_err         = act && s1_err;

`ifdef SD_MASK_EN
  assign bus.mask_valid = act;
  assign bus.mask_bit   = act && !first_frame &&
                          (abs_diff(s1_pix, bus.mem_rd_bg) > bus.mem_rd_var);
`else
  assign bus.mask_valid = 1'b0;
  assign bus.mask_bit   = 1'b0;
`endif

endmodule
